// File: rtl/ines_pkg.sv
// ines_pkg: shared definitions for the iNES cartridge image loader.
//   state_t       - loader FSM states
//   INES_MAGIC    - "NES\x1A" signature expected in header bytes 0..3
//   OFF_*         - byte offsets of the header fields the loader uses
//   *_LEN, *_SIZE - trainer length and PRG/CHR bank sizes in bytes
//   magic_byte()  - signature byte expected at header index 0..3
package ines_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [31:0] INES_MAGIC = 32'h4E45531A;

  localparam logic [3:0] OFF_PRG_BANKS = 4'd4;
  localparam logic [3:0] OFF_CHR_BANKS = 4'd5;
  localparam logic [3:0] OFF_FLAGS6    = 4'd6;
  localparam logic [3:0] OFF_FLAGS7    = 4'd7;
  localparam logic [3:0] OFF_LAST      = 4'd15;

  localparam int unsigned TRAINER_LEN   = 512;
  localparam int unsigned PRG_BANK_SIZE = 16384;
  localparam int unsigned CHR_BANK_SIZE = 8192;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INES_MAGIC[31:24];
      2'd1:    b = INES_MAGIC[23:16];
      2'd2:    b = INES_MAGIC[15:8];
      default: b = INES_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES image arriving as a valid/ready byte stream and
// writes its PRG and CHR payload into the cartridge memories.
//   clk_cpu, rst              - single clock, synchronous active-high reset
//   s_data/s_valid/s_ready    - incoming iNES byte stream
//   prg_we/chr_we/wr_addr/wr_data - one-cycle write strobes into PRG or CHR memory
//   mapper, prg_banks, chr_banks, chr_ram, mirroring, battery - decoded header
//   done, error               - sticky load-complete / bad-image flags
//   cart_rst                  - holds the cartridge in reset until the load is done
// Requires 14 <= PRG_ROM_DEPTH and CHR_ROM_DEPTH <= PRG_ROM_DEPTH.
module ines_loader
  import ines_pkg::*;
#(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 13
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     prg_we,
  output logic                     chr_we,
  output logic [PRG_ROM_DEPTH-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic [7:0]               mapper,
  output logic [7:0]               prg_banks,
  output logic [7:0]               chr_banks,
  output logic                     chr_ram,
  output logic                     mirroring,
  output logic                     battery,
  output logic                     done,
  output logic                     error,
  output logic                     cart_rst
);

  // One extra bit so a full-capacity end count is representable.
  localparam int          CW      = PRG_ROM_DEPTH + 1;
  localparam logic [31:0] PRG_CAP = 32'd1 << PRG_ROM_DEPTH;
  localparam logic [31:0] CHR_CAP = 32'd1 << CHR_ROM_DEPTH;

  state_t        state;
  logic [3:0]    hdr_idx;
  logic [CW-1:0] cnt;
  logic          magic_ok;
  logic          trainer;

  logic          accept;
  logic          magic_hit;
  logic          hdr_bad;
  logic [31:0]   prg_bytes;
  logic [31:0]   chr_bytes;
  logic [CW-1:0] prg_last_idx;
  logic [CW-1:0] chr_last_idx;
  logic [CW-1:0] trn_last_idx;

  assign accept       = s_valid && s_ready;
  assign magic_hit    = (s_data == magic_byte(hdr_idx[1:0]));
  assign prg_bytes    = 32'(prg_banks) * PRG_BANK_SIZE;
  assign chr_bytes    = 32'(chr_banks) * CHR_BANK_SIZE;
  assign prg_last_idx = CW'(prg_bytes - 32'd1);
  assign chr_last_idx = CW'(chr_bytes - 32'd1);
  assign trn_last_idx = CW'(TRAINER_LEN - 32'd1);

  // Evaluated while the 16th header byte is accepted; every field it looks at
  // was latched by an earlier byte.
  assign hdr_bad = !magic_ok || (prg_banks == 8'd0) ||
                   (prg_bytes > PRG_CAP) || (chr_bytes > CHR_CAP);

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state     <= ST_HDR;
      hdr_idx   <= '0;
      cnt       <= '0;
      magic_ok  <= 1'b1;
      trainer   <= 1'b0;
      s_ready   <= 1'b1;
      prg_we    <= 1'b0;
      chr_we    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      mapper    <= '0;
      prg_banks <= '0;
      chr_banks <= '0;
      chr_ram   <= 1'b0;
      mirroring <= 1'b0;
      battery   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cart_rst  <= 1'b1;
    end else begin
      prg_we   <= 1'b0;
      chr_we   <= 1'b0;
      // Follows done one cycle late.
      cart_rst <= !done;
      case (state)
        ST_HDR: begin
          if (accept) begin
            hdr_idx <= hdr_idx + 4'd1;
            if ((hdr_idx[3:2] == 2'b00) && !magic_hit) magic_ok <= 1'b0;
            case (hdr_idx)
              OFF_PRG_BANKS: prg_banks <= s_data;
              OFF_CHR_BANKS: begin
                chr_banks <= s_data;
                chr_ram   <= (s_data == 8'd0);
              end
              OFF_FLAGS6: begin
                mirroring   <= s_data[0];
                battery     <= s_data[1];
                trainer     <= s_data[2];
                mapper[3:0] <= s_data[7:4];
              end
              OFF_FLAGS7: mapper[7:4] <= s_data[7:4];
              default: ;
            endcase
            if (hdr_idx == OFF_LAST) begin
              cnt <= '0;
              if (hdr_bad) begin
                state   <= ST_ERR;
                error   <= 1'b1;
                s_ready <= 1'b0;
              end else if (trainer) begin
                state <= ST_TRAINER;
              end else begin
                state <= ST_PRG;
              end
            end
          end
        end
        ST_TRAINER: begin
          if (accept) begin
            if (cnt == trn_last_idx) begin
              cnt   <= '0;
              state <= ST_PRG;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_PRG: begin
          if (accept) begin
            prg_we  <= 1'b1;
            wr_addr <= cnt[PRG_ROM_DEPTH-1:0];
            wr_data <= s_data;
            if (cnt == prg_last_idx) begin
              cnt <= '0;
              if (chr_banks != 8'd0) begin
                state <= ST_CHR;
              end else begin
                state   <= ST_DONE;
                done    <= 1'b1;
                s_ready <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_CHR: begin
          if (accept) begin
            chr_we  <= 1'b1;
            wr_addr <= cnt[PRG_ROM_DEPTH-1:0];
            wr_data <= s_data;
            if (cnt == chr_last_idx) begin
              cnt     <= '0;
              state   <= ST_DONE;
              done    <= 1'b1;
              s_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: self-checking bench for ines_loader. Builds random iNES
// images, streams them in, and compares the observed memory writes and header
// outputs against a reference computed directly from the iNES layout rules.
module tb_ines_loader;

  localparam int PD = 15;
  localparam int CD = 13;
  localparam int VW = 3 + PD + 8 + 24 + 6;

  logic          clk_cpu = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          prg_we;
  logic          chr_we;
  logic [PD-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    mapper;
  logic [7:0]    prg_banks;
  logic [7:0]    chr_banks;
  logic          chr_ram;
  logic          mirroring;
  logic          battery;
  logic          done;
  logic          error;
  logic          cart_rst;

  ines_loader #(.PRG_ROM_DEPTH(PD), .CHR_ROM_DEPTH(CD)) dut (
    .clk_cpu(clk_cpu), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .prg_we(prg_we), .chr_we(chr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .mapper(mapper), .prg_banks(prg_banks), .chr_banks(chr_banks),
    .chr_ram(chr_ram), .mirroring(mirroring), .battery(battery),
    .done(done), .error(error), .cart_rst(cart_rst)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct packed {
    logic        is_chr;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] file_q[$];
  wr_t        obs_q[$];
  wr_t        exp_q[$];

  int checks = 0;
  int errors = 0;

  // Stream observations
  int stray, both_hi, acc_total, done_cyc, crst_cyc, err_cyc, hdr_cyc;
  // Reference model results
  logic       m_err;
  logic [7:0] m_mapper;
  logic [7:0] m_prg, m_chr;
  logic       m_chr_ram, m_mirror, m_battery;

  localparam logic [VW-1:0] RESET_VEC = {1'b1, {(VW-2){1'b0}}, 1'b1};

  function automatic logic [VW-1:0] out_vec();
    return {s_ready, prg_we, chr_we, wr_addr, wr_data, mapper, prg_banks, chr_banks,
            chr_ram, mirroring, battery, done, error, cart_rst};
  endfunction

  function automatic logic [29:0] hdr_vec();
    return {mapper, prg_banks, chr_banks, chr_ram, mirroring, battery};
  endfunction

  function automatic logic [29:0] model_hdr_vec();
    return {m_mapper, m_prg, m_chr, m_chr_ram, m_mirror, m_battery};
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    @(posedge clk_cpu); #1;
    rst = 1'b0;
  endtask

  task automatic make_file(input logic [7:0] b0, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6, input logic [7:0] b7, input int pay_len);
    file_q.delete();
    file_q.push_back(b0);   file_q.push_back(8'h45);
    file_q.push_back(8'h53); file_q.push_back(8'h1A);
    file_q.push_back(b4);   file_q.push_back(b5);
    file_q.push_back(b6);   file_q.push_back(b7);
    for (int k = 0; k < 8; k++) file_q.push_back(8'h00);
    for (int k = 0; k < pay_len; k++) file_q.push_back(8'($urandom));
  endtask

  // Reference: which payload byte lands where, derived from the file layout.
  task automatic build_model();
    logic [7:0] h[16];
    int t, np, nc, p;
    wr_t w;
    for (int i = 0; i < 16; i++) h[i] = file_q[i];
    m_err = !(h[0] == 8'h4E && h[1] == 8'h45 && h[2] == 8'h53 && h[3] == 8'h1A) ||
            (h[4] == 8'h00) || (int'(h[4]) * 16384 > (1 << PD)) ||
            (int'(h[5]) * 8192 > (1 << CD));
    m_mapper  = {h[7][7:4], h[6][7:4]};
    m_prg     = h[4];
    m_chr     = h[5];
    m_chr_ram = (h[5] == 8'h00);
    m_mirror  = h[6][0];
    m_battery = h[6][1];
    exp_q.delete();
    if (!m_err) begin
      t  = h[6][2] ? 512 : 0;
      np = int'(h[4]) * 16384;
      nc = int'(h[5]) * 8192;
      for (int k = 0; k < file_q.size() - 16; k++) begin
        p = k - t;
        if (p >= 0 && p < np + nc) begin
          w.is_chr = (p >= np);
          w.addr   = (p >= np) ? 32'(p - np) : 32'(p);
          w.data   = file_q[16 + k];
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // Drives file_q with random s_valid gaps and records every write strobe.
  task automatic stream(input int gap_pct);
    int idx, cyc, tail, limit;
    logic rdy, acc;
    wr_t w;
    obs_q.delete();
    stray = 0; both_hi = 0; acc_total = 0;
    done_cyc = -1; crst_cyc = -1; err_cyc = -1; hdr_cyc = -1;
    idx = 0; cyc = 0; tail = 0;
    limit = file_q.size() * 4 + 100;
    while (tail < 4) begin
      if (idx < file_q.size()) begin
        s_data  = file_q[idx];
        s_valid = ($urandom_range(0, 99) >= gap_pct);
      end else begin
        s_data  = 8'h00;
        s_valid = 1'b0;
      end
      rdy = s_ready;
      @(posedge clk_cpu); #1;
      cyc++;
      acc = s_valid && rdy;
      if (acc) begin
        idx++;
        acc_total++;
        if (acc_total == 16) hdr_cyc = cyc;
      end
      if (prg_we || chr_we) begin
        if (!acc) stray++;
        if (prg_we && chr_we) both_hi++;
        w.is_chr = chr_we;
        w.addr   = 32'(wr_addr);
        w.data   = wr_data;
        obs_q.push_back(w);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (!cart_rst && crst_cyc < 0) crst_cyc = cyc;
      if (error && err_cyc < 0) err_cyc = cyc;
      if (idx >= file_q.size() || !s_ready || cyc >= limit) tail++;
    end
    s_valid = 1'b0;
  endtask

  function automatic int write_mismatches(output string first);
    int bad;
    bad = 0;
    first = "none";
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      first = $sformatf("write count %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        if (bad == 0)
          first = $sformatf("#%0d got chr=%0d a=%0h d=%0h required chr=%0d a=%0h d=%0h", i,
                            obs_q[i].is_chr, obs_q[i].addr, obs_q[i].data,
                            exp_q[i].is_chr, exp_q[i].addr, exp_q[i].data);
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int count_kind(input logic is_chr);
    int n;
    n = 0;
    foreach (obs_q[i]) if (obs_q[i].is_chr == is_chr) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk_cpu);
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_outputs: got %h required %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    @(posedge clk_cpu); #1;
    checks++;
    if ({s_ready, done, error, cart_rst} !== 4'b1001) begin
      errors++; $display("FAIL idle_after_reset: got %b required 1001", {s_ready, done, error, cart_rst});
    end
  endtask

  task automatic test_nrom();
    string msg;
    int nbad, ign_bad;
    do_reset();
    make_file(8'h4E, 8'h02, 8'h01, 8'h00, 8'h00, 32768 + 8192);
    build_model();
    stream(0);
    nbad = write_mismatches(msg);
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL nrom_writes: %0d bad, %s", nbad, msg); end
    checks++;
    if (count_kind(1'b0) !== 32768) begin
      errors++; $display("FAIL nrom_prg_count: got %0d required 32768", count_kind(1'b0));
    end
    checks++;
    if (count_kind(1'b1) !== 8192) begin
      errors++; $display("FAIL nrom_chr_count: got %0d required 8192", count_kind(1'b1));
    end
    checks++;
    if (acc_total !== 16 + 40960) begin
      errors++; $display("FAIL nrom_accepted: got %0d required %0d", acc_total, 16 + 40960);
    end
    checks++;
    if (stray !== 0 || both_hi !== 0) begin
      errors++; $display("FAIL nrom_strobes: stray %0d both %0d required 0 0", stray, both_hi);
    end
    checks++;
    if ({done, error, s_ready} !== 3'b100) begin
      errors++; $display("FAIL nrom_status: got %b required 100", {done, error, s_ready});
    end
    checks++;
    if (hdr_vec() !== model_hdr_vec()) begin
      errors++; $display("FAIL nrom_header: got %h required %h", hdr_vec(), model_hdr_vec());
    end
    checks++;
    if (done_cyc < 0 || crst_cyc !== done_cyc + 1) begin
      errors++; $display("FAIL nrom_cart_rst: fell at %0d required %0d", crst_cyc, done_cyc + 1);
    end
    ign_bad = 0;
    for (int k = 0; k < 6; k++) begin
      s_valid = 1'b1; s_data = 8'($urandom);
      @(posedge clk_cpu); #1;
      if (prg_we || chr_we || !done || s_ready || cart_rst) ign_bad++;
    end
    s_valid = 1'b0;
    checks++;
    if (ign_bad !== 0) begin errors++; $display("FAIL done_ignores_bytes: got %0d bad cycles required 0", ign_bad); end
  endtask

  task automatic test_mapper1();
    string msg;
    int nbad;
    do_reset();
    make_file(8'h4E, 8'h01, 8'h00, 8'h12, 8'h00, 16384);
    build_model();
    stream(0);
    nbad = write_mismatches(msg);
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL mmc1_writes: %0d bad, %s", nbad, msg); end
    checks++;
    if ({mapper, battery, chr_ram} !== {8'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mmc1_header: got mapper %0d bat %b chr_ram %b required 1 1 1",
                         mapper, battery, chr_ram);
    end
    checks++;
    if (count_kind(1'b1) !== 0 || count_kind(1'b0) !== 16384) begin
      errors++; $display("FAIL mmc1_counts: prg %0d chr %0d required 16384 0", count_kind(1'b0), count_kind(1'b1));
    end
    checks++;
    if ({done, error} !== 2'b10) begin errors++; $display("FAIL mmc1_done: got %b required 10", {done, error}); end
  endtask

  task automatic test_trainer();
    string msg;
    int nbad;
    do_reset();
    make_file(8'h4E, 8'h01, 8'h00, 8'h05, 8'h10, 512 + 16384);
    build_model();
    stream(15);
    checks++;
    if (obs_q.size() == 0 || obs_q[0].data !== file_q[16 + 512] || obs_q[0].addr !== 32'd0 || obs_q[0].is_chr !== 1'b0) begin
      errors++; $display("FAIL trainer_first_write: got n=%0d required data %h at addr 0",
                         obs_q.size(), file_q[16 + 512]);
    end
    nbad = write_mismatches(msg);
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL trainer_writes: %0d bad, %s", nbad, msg); end
    checks++;
    if (hdr_vec() !== model_hdr_vec()) begin
      errors++; $display("FAIL trainer_header: got %h required %h", hdr_vec(), model_hdr_vec());
    end
    checks++;
    if (stray !== 0 || done !== 1'b1) begin
      errors++; $display("FAIL trainer_gaps: stray %0d done %b required 0 1", stray, done);
    end
  endtask

  task automatic test_bad_magic();
    do_reset();
    make_file(8'h4F, 8'h01, 8'h00, 8'h00, 8'h00, 32);
    build_model();
    stream(0);
    checks++;
    if ({error, done, s_ready, cart_rst} !== {m_err, 3'b001}) begin
      errors++; $display("FAIL magic_status: got %b required %b", {error, done, s_ready, cart_rst}, {m_err, 3'b001});
    end
    checks++;
    if (obs_q.size() !== 0 || acc_total !== 16) begin
      errors++; $display("FAIL magic_no_writes: writes %0d accepted %0d required 0 16", obs_q.size(), acc_total);
    end
    checks++;
    if (hdr_cyc < 0 || err_cyc !== hdr_cyc) begin
      errors++; $display("FAIL magic_err_timing: error at %0d required %0d", err_cyc, hdr_cyc);
    end
  endtask

  task automatic test_bad_headers();
    logic [15:0] cases[3];
    cases[0] = 16'h1000;  // 16 PRG banks: far above capacity
    cases[1] = 16'h0001;  // zero PRG banks
    cases[2] = 16'h0102;  // 2 CHR banks: above CHR capacity
    for (int c = 0; c < 3; c++) begin
      do_reset();
      make_file(8'h4E, cases[c][15:8], cases[c][7:0], 8'h00, 8'h00, 64);
      build_model();
      stream(0);
      checks++;
      if ({error, done, s_ready, cart_rst} !== {m_err, 3'b001} || obs_q.size() !== 0) begin
        errors++; $display("FAIL bad_header_%0d: status %b writes %0d required %b 0",
                           c, {error, done, s_ready, cart_rst}, obs_q.size(), {m_err, 3'b001});
      end
    end
  endtask

  task automatic test_reset_midstream();
    string msg;
    int nbad;
    do_reset();
    make_file(8'h4E, 8'h02, 8'h00, 8'h00, 8'h00, 100);
    build_model();
    stream(50);
    nbad = write_mismatches(msg);
    checks++;
    if (nbad !== 0 || stray !== 0) begin
      errors++; $display("FAIL pre_rst_writes: %0d bad stray %0d, %s", nbad, stray, msg);
    end
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h4E;
    @(posedge clk_cpu); #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++; $display("FAIL midstream_reset: got %h required %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0; s_valid = 1'b0;
    make_file(8'h4E, 8'h01, 8'h01, 8'h03, 8'h20, 300);
    build_model();
    stream(30);
    nbad = write_mismatches(msg);
    checks++;
    if (nbad !== 0 || obs_q.size() == 0 || obs_q[0].addr !== 32'd0) begin
      errors++; $display("FAIL reload_writes: %0d bad, %s", nbad, msg);
    end
    checks++;
    if (hdr_vec() !== model_hdr_vec() || done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reload_header: got %h d%b e%b required %h d0 e0",
                         hdr_vec(), done, error, model_hdr_vec());
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    test_reset();
    test_nrom();
    test_mapper1();
    test_trainer();
    test_bad_magic();
    test_bad_headers();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
